// File: rtl/game_master_rounds_fsm_pkg.sv
// game_master_rounds_fsm_pkg: state encoding, score constants and width helper for the game master
package game_master_rounds_fsm_pkg;
  localparam logic [2:0] ST_START  = 3'd0;
  localparam logic [2:0] ST_AIM    = 3'd1;
  localparam logic [2:0] ST_SHOOT  = 3'd2;
  localparam logic [2:0] ST_RELOAD = 3'd3;
  localparam logic [2:0] ST_END    = 3'd4;
  localparam logic [2:0] ST_OVER   = 3'd5;
  localparam logic [15:0] SCORE_UNIT = 16'd10;
  localparam logic [15:0] SCORE_MAX  = 16'hFFFF;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/game_master_rounds_fsm_rise_edge_detect.sv
// game_master_rounds_fsm_rise_edge_detect: one-cycle pulse on a rising edge of a level input
module game_master_rounds_fsm_rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic q;
  // previous sample of d, tracked every cycle regardless of game state
  always_ff @(posedge clk) q <= reset ? 1'b0 : d;
  assign rise = d & ~q;
endmodule

// File: rtl/game_master_rounds_fsm.sv
// game_master_rounds_fsm: round/shot game master driving target and torpedo sprites (optional score via GAME_MASTER_SCORE_EN)
module game_master_rounds_fsm
  import game_master_rounds_fsm_pkg::*;
#(
  parameter int MAX_SHOTS = 3,
  parameter int ROUNDS    = 4,
  parameter int SHOT_W    = clog2(MAX_SHOTS + 1),
  parameter int ROUND_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  input  logic               sprite_target_within_screen,
  input  logic               sprite_torpedo_within_screen,
  input  logic               collision,
  input  logic               end_of_game_timer_running,
  output logic               sprite_target_write_xy,
  output logic               sprite_target_write_dxy,
  output logic               sprite_target_enable_update,
  output logic               sprite_torpedo_write_xy,
  output logic               sprite_torpedo_write_dxy,
  output logic               sprite_torpedo_enable_update,
  output logic               end_of_game_timer_start,
  output logic               round_won,
  output logic [SHOT_W-1:0]  shots_left,
  output logic [ROUND_W-1:0] round,
  output logic [ROUND_W-1:0] hits,
  output logic               game_over
`ifdef GAME_MASTER_SCORE_EN
  , output logic [15:0]      score
`endif
);
  logic [2:0] state, state_n;
  logic key_rise;
  logic tgt_wxy_n, tgt_wdxy_n, tor_wxy_n, timer_start_n, round_won_n;
  logic [SHOT_W-1:0] shots_n;
  logic [ROUND_W-1:0] round_n, hits_n;
  game_master_rounds_fsm_rise_edge_detect u_key_edge (
    .clk  (clk),
    .reset(reset),
    .d    (key),
    .rise (key_rise)
  );
  // next-state and next-output decision; outputs are registered so strobes lag the decision by one cycle
  always_comb begin
    state_n = state;
    tgt_wxy_n = 1'b0;
    tgt_wdxy_n = 1'b0;
    tor_wxy_n = 1'b0;
    timer_start_n = 1'b0;
    round_won_n = round_won;
    shots_n = shots_left;
    round_n = round;
    hits_n = hits;
    case (state)
      ST_START: begin
        tgt_wxy_n = 1'b1;
        tgt_wdxy_n = 1'b1;
        tor_wxy_n = 1'b1;
        shots_n = SHOT_W'(MAX_SHOTS);
        round_won_n = 1'b0;
        state_n = ST_AIM;
      end
      ST_AIM: begin
        if (key_rise && shots_left != '0) begin
          shots_n = shots_left - 1'b1;
          state_n = ST_SHOOT;
        end else if (!sprite_target_within_screen) begin
          timer_start_n = 1'b1;
          state_n = ST_END;
        end
      end
      ST_SHOOT: begin
        if (collision) begin
          round_won_n = 1'b1;
          hits_n = (hits == ROUND_W'(ROUNDS)) ? hits : hits + 1'b1;
          timer_start_n = 1'b1;
          state_n = ST_END;
        end else if (!sprite_target_within_screen) begin
          timer_start_n = 1'b1;
          state_n = ST_END;
        end else if (!sprite_torpedo_within_screen) begin
          timer_start_n = (shots_left == '0);
          state_n = (shots_left != '0) ? ST_RELOAD : ST_END;
        end
      end
      ST_RELOAD: begin
        tor_wxy_n = 1'b1;
        state_n = ST_AIM;
      end
      ST_END: begin
        // the cycle carrying timer_start is skipped so a one-cycle timer latency cannot end the pause early
        if (!end_of_game_timer_start && !end_of_game_timer_running) begin
          round_n = (round == ROUND_W'(ROUNDS - 1)) ? round : round + 1'b1;
          state_n = (round == ROUND_W'(ROUNDS - 1)) ? ST_OVER : ST_START;
        end
      end
      ST_OVER: begin
        if (key_rise) begin
          round_n = '0;
          hits_n = '0;
          state_n = ST_START;
        end
      end
      default: state_n = ST_START;
    endcase
  end
  // output and state registers; levels follow the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_START;
      sprite_target_write_xy <= 1'b0;
      sprite_target_write_dxy <= 1'b0;
      sprite_target_enable_update <= 1'b0;
      sprite_torpedo_write_xy <= 1'b0;
      sprite_torpedo_write_dxy <= 1'b0;
      sprite_torpedo_enable_update <= 1'b0;
      end_of_game_timer_start <= 1'b0;
      round_won <= 1'b0;
      shots_left <= SHOT_W'(MAX_SHOTS);
      round <= '0;
      hits <= '0;
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      sprite_target_write_xy <= tgt_wxy_n;
      sprite_target_write_dxy <= tgt_wdxy_n;
      sprite_target_enable_update <= (state_n == ST_AIM) || (state_n == ST_SHOOT) || (state_n == ST_RELOAD);
      sprite_torpedo_write_xy <= tor_wxy_n;
      sprite_torpedo_write_dxy <= (state_n == ST_SHOOT);
      sprite_torpedo_enable_update <= (state_n == ST_SHOOT);
      end_of_game_timer_start <= timer_start_n;
      round_won <= round_won_n;
      shots_left <= shots_n;
      round <= round_n;
      hits <= hits_n;
      game_over <= (state_n == ST_OVER);
    end
  end
`ifdef GAME_MASTER_SCORE_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + 17'(SCORE_UNIT) * 17'(shots_left) + 17'(SCORE_UNIT);
  // hit bonus rewards the shots still in hand; a fresh game starts from zero
  always_ff @(posedge clk) begin
    if (reset || (state == ST_OVER && key_rise)) score <= '0;
    else if (state == ST_SHOOT && collision) score <= score_sum[16] ? SCORE_MAX : score_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_game_master_rounds_fsm.sv
// tb_game_master_rounds_fsm: directed self-checking bench for game_master_rounds_fsm (MAX_SHOTS=3, ROUNDS=4)
module tb_game_master_rounds_fsm;
  logic clk = 1'b0, reset = 1'b1, key = 1'b0;
  logic tgt_in = 1'b1, tor_in = 1'b1, coll = 1'b0, trun = 1'b0;
  logic tgt_wxy, tgt_wdxy, tgt_en, tor_wxy, tor_wdxy, tor_en, ts, round_won, game_over;
  logic [1:0] shots;
  logic [2:0] round, hits;
`ifdef GAME_MASTER_SCORE_EN
  logic [15:0] score;
`endif
  int total = 0, passed = 0;
  game_master_rounds_fsm dut (
    .clk                         (clk),
    .reset                       (reset),
    .key                         (key),
    .sprite_target_within_screen (tgt_in),
    .sprite_torpedo_within_screen(tor_in),
    .collision                   (coll),
    .end_of_game_timer_running   (trun),
    .sprite_target_write_xy      (tgt_wxy),
    .sprite_target_write_dxy     (tgt_wdxy),
    .sprite_target_enable_update (tgt_en),
    .sprite_torpedo_write_xy     (tor_wxy),
    .sprite_torpedo_write_dxy    (tor_wdxy),
    .sprite_torpedo_enable_update(tor_en),
    .end_of_game_timer_start     (ts),
    .round_won                   (round_won),
    .shots_left                  (shots),
    .round                       (round),
    .hits                        (hits),
    .game_over                   (game_over)
`ifdef GAME_MASTER_SCORE_EN
    , .score                     (score)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  // expected bits: {tgt_wxy, tgt_wdxy, tgt_en, tor_wxy, tor_wdxy, tor_en, timer_start, game_over}
  task automatic chk_o(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, tgt_wxy, tgt_wdxy, tgt_en, tor_wxy, tor_wdxy, tor_en, ts, game_over}, {24'd0, exp});
  endtask
  task automatic chk_score(input string tag, input logic [15:0] exp);
`ifdef GAME_MASTER_SCORE_EN
    chk(tag, {16'd0, score}, {16'd0, exp});
`endif
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    tick;
    chk_o("rst_out", 8'b0000_0000);
    chk("rst_shots", shots, 3);
    chk("rst_round", round, 0);
    chk("rst_hits", hits, 0);
    chk("rst_won", round_won, 0);
    chk_score("rst_score", 0);
    reset = 1'b0;
    tick;
    chk_o("start0", 8'b1111_0000);
    key = 1'b1;
    tick;
    key = 1'b0;
    chk_o("shoot0", 8'b0010_1100);
    chk("shoot0_shots", shots, 2);
    repeat (4) tick;
    chk_o("flight", 8'b0010_1100);
    coll = 1'b1;
    tick;
    coll = 1'b0;
    trun = 1'b1;
    chk_o("hit0", 8'b0000_0010);
    chk("hit0_won", round_won, 1);
    chk("hit0_hits", hits, 1);
    chk("hit0_shots", shots, 2);
    chk_score("hit0_score", 30);
    tick;
    chk_o("end_pulse_once", 8'b0000_0000);
    tick;
    chk("end_wait_round", round, 0);
    trun = 1'b0;
    tick;
    chk("next_round", round, 1);
    chk_o("restart", 8'b0000_0000);
    tick;
    chk_o("start1", 8'b1111_0000);
    chk("start1_won", round_won, 0);
    chk("start1_shots", shots, 3);
    key = 1'b1;
    tick;
    key = 1'b0;
    tor_in = 1'b0;
    tick;
    tor_in = 1'b1;
    chk_o("reload1", 8'b0010_0000);
    chk("reload1_shots", shots, 2);
    tick;
    chk_o("repark1", 8'b0011_0000);
    key = 1'b1;
    tick;
    key = 1'b0;
    tor_in = 1'b0;
    tick;
    tor_in = 1'b1;
    chk("reload2_shots", shots, 1);
    tick;
    chk_o("repark2", 8'b0011_0000);
    key = 1'b1;
    tick;
    key = 1'b0;
    chk("shot3_shots", shots, 0);
    tor_in = 1'b0;
    tick;
    tor_in = 1'b1;
    chk_o("last_exit", 8'b0000_0010);
    chk("last_exit_shots", shots, 0);
    chk("last_exit_won", round_won, 0);
    repeat (3) tick;
    chk("round2", round, 2);
    chk_o("start2", 8'b1111_0000);
    key = 1'b1;
    tick;
    tor_in = 1'b0;
    tick;
    tor_in = 1'b1;
    repeat (18) tick;
    chk_o("held_key", 8'b0010_0000);
    chk("held_shots", shots, 2);
    key = 1'b0;
    tick;
    key = 1'b1;
    tick;
    key = 1'b0;
    chk("shot4_shots", shots, 1);
    coll = 1'b1;
    tor_in = 1'b0;
    tick;
    coll = 1'b0;
    tor_in = 1'b1;
    chk_o("hit_exit", 8'b0000_0010);
    chk("hit_exit_hits", hits, 2);
    chk("hit_exit_won", round_won, 1);
    chk("hit_exit_shots", shots, 1);
    chk_score("hit_exit_score", 50);
    tick;
    chk_o("no_reload", 8'b0000_0000);
    repeat (2) tick;
    chk("round3", round, 3);
    tgt_in = 1'b0;
    tick;
    tgt_in = 1'b1;
    chk_o("tgt_out", 8'b0000_0010);
    repeat (2) tick;
    chk_o("over", 8'b0000_0001);
    chk("over_round", round, 3);
    chk("over_hits", hits, 2);
    tick;
    chk_o("over_hold", 8'b0000_0001);
    key = 1'b1;
    tick;
    key = 1'b0;
    chk_o("new_game", 8'b0000_0000);
    chk("new_game_round", round, 0);
    chk("new_game_hits", hits, 0);
    chk_score("new_game_score", 0);
    tick;
    chk_o("ng_start", 8'b1111_0000);
    key = 1'b1;
    tick;
    key = 1'b0;
    chk_o("pre_rst_shoot", 8'b0010_1100);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_o("mid_rst", 8'b0000_0000);
    chk("mid_rst_shots", shots, 3);
    chk("mid_rst_round", round, 0);
    chk("mid_rst_won", round_won, 0);
    tick;
    key = 1'b1;
    tick;
    key = 1'b0;
    coll = 1'b1;
    tick;
    coll = 1'b0;
    chk("post_rst_hits", hits, 1);
    chk_score("post_rst_score", 30);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
